tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving the enables of N tristate buffers on one shared bus.
// Limits each tenure to MAX_HOLD cycles and inserts TURN_CYC idle cycles between owners.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         sel,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 bus_busy,
    output logic                 timeout
);

    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    logic [1:0]    state_r, state_s;
    logic [N-1:0]  sel_r, sel_s;
    logic [OW-1:0] owner_r, owner_s;
    logic [OW-1:0] last_r, last_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [TW-1:0] turn_r, turn_s;
    logic          busy_r, busy_s;
    logic          timeout_r, timeout_s;
    logic          found_s;
    logic [OW-1:0] pick_s;
    logic [N-1:0]  onehot_s;

    // Round-robin search starting just after the most recent owner
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && req[OW'((int'(last_r) + k) % N)]) begin
                found_s = 1'b1;
                pick_s  = OW'((int'(last_r) + k) % N);
            end else begin
                found_s = found_s;
            end
        end
        onehot_s = {{(N-1){1'b0}}, 1'b1} << pick_s;
    end

    // Next-state and next-output computation for the IDLE/GRANT/TURN machine
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        owner_s   = owner_r;
        last_s    = last_r;
        hold_s    = hold_r;
        turn_s    = turn_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = GRANT;
                    sel_s   = onehot_s;
                    owner_s = pick_s;
                    busy_s  = 1'b1;
                    hold_s  = HW'(1);
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                // Release on request drop or tenure expiry; expiry is the only case req is still high
                if (!req[owner_r] || (hold_r == HW'(MAX_HOLD))) begin
                    state_s   = TURN;
                    sel_s     = '0;
                    owner_s   = '0;
                    busy_s    = 1'b0;
                    last_s    = owner_r;
                    hold_s    = '0;
                    turn_s    = TW'(1);
                    timeout_s = req[owner_r];
                end else begin
                    hold_s = hold_r + HW'(1);
                end
            end
            TURN: begin
                if (turn_r == TW'(TURN_CYC)) begin
                    turn_s = '0;
                    if (found_s) begin
                        state_s = GRANT;
                        sel_s   = onehot_s;
                        owner_s = pick_s;
                        busy_s  = 1'b1;
                        hold_s  = HW'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    turn_s = turn_r + TW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = '0;
                owner_s = '0;
                busy_s  = 1'b0;
                hold_s  = '0;
                turn_s  = '0;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            owner_r   <= '0;
            last_r    <= OW'(N - 1);
            hold_r    <= '0;
            turn_r    <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            sel_r     <= sel_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            hold_r    <= hold_s;
            turn_r    <= turn_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign sel      = sel_r;
    assign grant    = sel_r;
    assign owner    = owner_r;
    assign bus_busy = busy_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, MAX_HOLD=8, TURN_CYC=1):
// vector table for short sequences, loops for long hold/expiry patterns, per-cycle bus checks.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] sel;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    int vectors    = 0;
    int miscompares = 0;

    tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .grant(grant),
        .owner(owner), .bus_busy(bus_busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sel;
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [18];

    task automatic cmp(input string nm, input int idx, input logic [3:0] esel,
                       input logic [1:0] eown, input logic ebusy, input logic eto);
        vectors++;
        if (sel !== esel || grant !== esel || owner !== eown || bus_busy !== ebusy || timeout !== eto) begin
            miscompares++;
            $display("FAIL %s[%0d]: got sel=%b grant=%b owner=%0d busy=%b timeout=%b, expected sel=%b grant=%b owner=%0d busy=%b timeout=%b",
                     nm, idx, sel, grant, owner, bus_busy, timeout, esel, esel, eown, ebusy, eto);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst_n = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle bus safety: one-hot-or-zero, grant mirrors sel, no owner-to-owner jump
    logic [3:0] prev_sel = 4'b0000;
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ($countones(sel) > 1 || grant !== sel ||
                (prev_sel != 4'b0000 && sel != 4'b0000 && sel != prev_sel)) begin
                miscompares++;
                $display("FAIL bus_check: got sel=%b grant=%b prev_sel=%b, expected onehot-or-zero, grant==sel, idle gap",
                         sel, grant, prev_sel);
            end
        end
        prev_sel = sel;
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;

        //            rst   req      sel      own   busy  to
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].req);
            cmp("table", i, tbl[i].sel, tbl[i].owner, tbl[i].busy, tbl[i].to);
        end

        // All four drivers requesting: 8-cycle tenures, one idle cycle, timeout in that idle cycle
        step(1'b0, 4'b1111);
        cmp("rr_reset", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            int pos;
            int grp;
            pos = c % 9;
            grp = (c / 9) % 4;
            step(1'b1, 4'b1111);
            if (pos < 8) cmp("rr_all", c, 4'(1 << grp), 2'(grp), 1'b1, 1'b0);
            else         cmp("rr_all", c, 4'b0000, 2'd0, 1'b0, 1'b1);
        end

        // Sole requester is regranted after each expiry
        step(1'b0, 4'b0010);
        cmp("solo_reset", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 4'b0010);
            if ((c % 9) < 8) cmp("solo", c, 4'b0010, 2'd1, 1'b1, 1'b0);
            else             cmp("solo", c, 4'b0000, 2'd0, 1'b0, 1'b1);
        end

        // Asynchronous reset in the middle of a grant
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        cmp("async_pre", 0, 4'b0100, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_now", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cmp("async_hold", 0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0100);
        cmp("async_post", 0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 4'b0100);
        cmp("async_post", 1, 4'b0100, 2'd2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
